// File: rtl/ex_div_pkg.sv
// Shared types and constants for the RV32M iterative divider controller.
package ex_div_pkg;

  localparam int unsigned DIV_XLEN = 32;
  localparam int unsigned CNT_W    = $clog2(DIV_XLEN + 1);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} div_state_e;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring shift-subtract iteration (purely combinational).
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN+1:0] shifted;
  logic [XLEN:0]   diff;
  logic            ge;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    ge       = (shifted >= {2'b00, dvs});
    diff     = shifted[XLEN:0] - {1'b0, dvs};
    rem_next = ge ? diff : shifted[XLEN:0];
    quo_next = {quo[XLEN-2:0], ge};
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU controller beside the execute ALU.
// Define DIV_FAST_SPECIAL_EN to short-cut divide-by-zero and signed overflow from PREP to DONE.
module ex_div_ctrl
  import ex_div_pkg::*;
#(
  parameter int unsigned XLEN  = DIV_XLEN,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_opa,
  input  logic [XLEN-1:0]  req_opb,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic             ex_stall
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state, state_nx;
  logic [2:0]       f3;
  logic [XLEN-1:0]  op_a, op_b, dvs, quo, quo_nx, result;
  logic [XLEN:0]    rem, rem_nx;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r;

  logic             accept, is_signed, want_rem, div_zero, div_ovf;
  logic [XLEN-1:0]  abs_a, abs_b, q_fix, r_fix, special_res, fix_res;

  assign accept    = (state == IDLE) & req_valid & ~flush;
  assign is_signed = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  assign want_rem  = (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
  assign abs_a     = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign abs_b     = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;
  assign div_zero  = (op_b == '0);
  assign div_ovf   = is_signed && (op_a == MIN_NEG) && (op_b == '1);

  // RISC-V defines these outright; the iterative path would give a wrong signed div-by-zero quotient.
  assign special_res = want_rem ? (div_zero ? op_a : '0) : (div_zero ? '1 : MIN_NEG);
  assign q_fix       = sign_q ? -quo : quo;
  assign r_fix       = sign_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  assign fix_res     = (div_zero || div_ovf) ? special_res : (want_rem ? r_fix : q_fix);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept) state_nx = PREP;
      end
      PREP: begin
        if (flush) state_nx = IDLE;
`ifdef DIV_FAST_SPECIAL_EN
        else if (div_zero || div_ovf) state_nx = DONE;
`endif
        else state_nx = RUN;
      end
      RUN: begin
        if (flush)                   state_nx = IDLE;
        else if (cnt == CNT_W'(1))   state_nx = FIX;
      end
      FIX: state_nx = flush ? IDLE : DONE;
      DONE: begin
        resp_valid = 1'b1;
        if (flush || resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f3     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      tag_q  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          f3    <= req_funct3;
          op_a  <= req_opa;
          op_b  <= req_opb;
          tag_q <= req_tag;
        end
        PREP: begin
          rem    <= '0;
          quo    <= abs_a;
          dvs    <= abs_b;
          cnt    <= CNT_W'(XLEN);
          sign_q <= is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
          sign_r <= is_signed & op_a[XLEN-1];
`ifdef DIV_FAST_SPECIAL_EN
          if (div_zero || div_ovf) result <= special_res;
`endif
        end
        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
        end
        FIX: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

  assign resp_result = result;
  assign resp_tag    = tag_q;
  assign ex_stall    = req_valid & ~req_ready;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: directed RV32M cases plus randomized ops vs. an arithmetic model.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, flush, resp_valid, resp_ready, busy, ex_stall;
  logic [2:0]  req_funct3;
  logic [31:0] req_opa, req_opb, resp_result;
  logic [4:0]  req_tag, resp_tag;

  int n_chk  = 0;
  int n_fail = 0;

  ex_div_ctrl #(.XLEN(32), .TAG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_opa     (req_opa),
    .req_opb     (req_opb),
    .req_tag     (req_tag),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_tag    (resp_tag),
    .busy        (busy),
    .ex_stall    (ex_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RISC-V division semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    bit     sgn;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  always @(negedge clk) chk("ex_stall", {31'd0, ex_stall}, {31'd0, req_valid & ~req_ready});

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, input bit flush_done);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    exp_res = ref_div(f3, a, b);
    exp_lat = 35;
`ifdef DIV_FAST_SPECIAL_EN
    if (b == 32'd0 || (f3[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) exp_lat = 2;
`endif
    req_funct3 = f3; req_opa = a; req_opb = b; req_tag = tag;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    step();
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 100) begin
      req_valid = 1'b0;
      step();
      lat++;
    end
    req_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", resp_result, exp_res);
    chk("tag", {27'd0, resp_tag}, {27'd0, tag});
    chk("busy_done", {31'd0, busy}, 32'd1);
    repeat (hold) begin
      step();
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_result", resp_result, exp_res);
      chk("hold_tag", {27'd0, resp_tag}, {27'd0, tag});
    end
    if (flush_done) flush = 1'b1;
    else            resp_ready = 1'b1;
    step();
    flush = 1'b0;
    resp_ready = 1'b0;
    chk("valid_after", {31'd0, resp_valid}, 32'd0);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic no_resp_window(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      step();
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_funct3 = 3'b100; req_opa = '0; req_opb = '0; req_tag = '0;
    flush = 1'b0; resp_ready = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_tag", {27'd0, resp_tag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    step();

    run_op(3'b100, 32'd100, 32'd7, 5'd3, 0, 1'b0);
    run_op(3'b110, 32'd100, 32'd7, 5'd4, 0, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b0);
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 1'b0);
    run_op(3'b101, 32'd5, 32'd0, 5'd8, 0, 1'b0);
    run_op(3'b111, 32'd5, 32'd0, 5'd9, 0, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd10, 0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 1'b0);

    // backpressure: 4 stalled cycles in DONE, handshake on the 5th
    run_op(3'b100, 32'd1000, 32'hFFFF_FFFD, 5'd13, 4, 1'b0);
    // flush while DONE drops the response
    run_op(3'b110, 32'd77, 32'd5, 5'd14, 1, 1'b1);

    // flush coincident with an acceptance edge
    req_funct3 = 3'b100; req_opa = 32'd50; req_opb = 32'd3; req_tag = 5'd15;
    req_valid = 1'b1; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_busy", {31'd0, busy}, 32'd0);
    no_resp_window("flush_accept_noresp", 40);

    // flush in RUN cycle 10
    req_funct3 = 3'b100; req_opa = 32'd12345; req_opb = 32'd7; req_tag = 5'd16;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (10) step();
    chk("run_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_run_busy", {31'd0, busy}, 32'd0);
    chk("flush_run_ready", {31'd0, req_ready}, 32'd1);
    no_resp_window("flush_run_noresp", 40);
    run_op(3'b101, 32'd9, 32'd3, 5'd26, 0, 1'b0);

    // asynchronous reset mid-RUN
    req_funct3 = 3'b110; req_opa = 32'd999; req_opb = 32'd10; req_tag = 5'd17;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (6) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_result", resp_result, 32'd0);
    #2 rst = 1'b1;
    step();
    no_resp_window("arst_noresp", 40);

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int unsigned sel;
      f3  = 3'b100 + 3'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(f3, a, b, 5'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
Multi-cycle controller for RV32M division (DIV, DIVU, REM, REMU) attached beside the single-cycle execute ALU. It accepts one operation from ID/EX, sequences a radix-2 restoring shift-subtract datapath for XLEN iterations, applies sign correction, and returns the result to the writeback path. While it is busy it raises an execute-stage stall. A pipeline flush kills it cleanly.

Parameters:
XLEN, 32, operand and result width.
TAG_W, 5, width of the destination tag (rd) carried with each operation.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  division operation offered by ID/EX
req_ready  out  1  controller can accept; high only in IDLE
req_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
req_opa  in  XLEN  dividend (rs1 value)
req_opb  in  XLEN  divisor (rs2 value)
req_tag  in  TAG_W  destination register tag
flush  in  1  kills the in-flight operation (branch taken or exception)
resp_valid  out  1  result available
resp_ready  in  1  writeback accepts the result
resp_result  out  XLEN  quotient or remainder
resp_tag  out  TAG_W  tag of the returned result
busy  out  1  high in any state other than IDLE
ex_stall  out  1  req_valid & ~req_ready

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. Outputs: req_ready=1, resp_valid=0, resp_result=0, resp_tag=0, busy=0. Iteration counter and all datapath registers are cleared. Reset during any state aborts the operation and no response is produced.
- Acceptance: an operation is accepted on a rising edge where req_valid & req_ready & ~flush. The controller latches funct3, the operands and the tag.
- States:
  - IDLE: waits for acceptance, then goes to PREP.
  - PREP: takes the absolute values of the operands for signed ops (funct3[0]=0). Records sign_q = opa[XLEN-1] ^ opb[XLEN-1] and sign_r = opa[XLEN-1]. Loads the counter with XLEN. Goes to RUN.
  - RUN: performs one shift-subtract step per cycle and decrements the counter. Goes to FIX when the counter reaches 0, after exactly XLEN cycles.
  - FIX: negates the quotient if sign_q is set and the remainder if sign_r is set (signed ops only). Selects the quotient when funct3[1]=0, otherwise the remainder. Goes to DONE.
  - DONE: resp_valid=1 and resp_result/resp_tag are held stable. Returns to IDLE on resp_valid & resp_ready.
- Latency: with acceptance at edge 0, resp_valid is first high in cycle XLEN+3 (cycle 35 for XLEN=32).
- Throughput: at most one operation in flight. The earliest new acceptance is the cycle after the response handshake; there is no same-cycle re-accept.
- Backpressure: if resp_ready is low in DONE, DONE is held indefinitely and all resp_* outputs stay stable.
- Special cases (RISC-V semantics):
  - Divisor 0: quotient = all ones, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
  - Without the optional feature, the iterative path plus FIX must produce these values; FIX forces them explicitly.
- Flush:
  - In PREP, RUN or FIX: state goes to IDLE on the next edge, no response is produced, and req_ready is high the following cycle.
  - In DONE: the response is dropped and resp_valid is low the next cycle.
  - Coincident with an acceptance edge: flush wins and nothing is accepted.
- Arithmetic: the partial remainder register is XLEN+1 bits. Negation is two's complement modulo 2^XLEN.

Optional Feature:
DIV_FAST_SPECIAL_EN
- Defined: PREP detects divisor 0 or signed overflow, loads the special result, and jumps directly to DONE. resp_valid is then high in cycle 2 after acceptance.
- Undefined: special cases take the full XLEN+3 latency, and FIX forces the special values.

Decomposition:
- Package ex_div_pkg contains:
  - a state enum {IDLE, PREP, RUN, FIX, DONE};
  - funct3 constants FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU;
  - the localparam CNT_W = $clog2(XLEN+1).
- One sub-module, div_step: a combinational single-iteration shift-subtract. Inputs: partial remainder, quotient and divisor. Outputs: next remainder and next quotient. It is instantiated once inside ex_div_ctrl.

Test Plan:
- DIV 100/7, resp_ready=1 → resp_result=14 (0x0000000E) in cycle 35. Same operands as REM → 2.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Both latencies checked with DIV_FAST_SPECIAL_EN defined (cycle 2) and undefined (cycle 35).
- Hold resp_ready low for 4 cycles in DONE → resp_valid, resp_result and resp_tag stable. Handshake on the 5th cycle → IDLE, and req_ready high the next cycle.
- Flush in RUN cycle 10 → no resp_valid ever, busy low the next cycle. A new DIVU 9/3 then returns 3 with the correct tag.
- Assert rst low mid-RUN → immediately req_ready=1, resp_valid=0, busy=0. ex_stall equals req_valid & ~req_ready in every cycle.
